// File: rtl/poly_sub_if.sv
// rtl/poly_sub_if.sv - source-read / result-write RAM bus of the coefficient subtract sequencer
interface poly_sub_if #(
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       dia;
  logic [15:0]       dib;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       dout;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, dout,
    input  dia, dib
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, dout,
    output dia, dib
  );
endinterface

// File: rtl/poly_sub.sv
// rtl/poly_sub.sv - streams c = (a - b) mod 12289 over N coefficients from two source RAMs to a result RAM
module poly_sub #(
  parameter int N      = 1024,
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  poly_sub_if.master    mem
);
  localparam logic [16:0] Q  = 17'd12289;
  localparam logic [16:0] Q2 = 17'd24578;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic              d_vld;
  logic [ADDR_W-1:0] d_addr;
  logic              t_vld;
  logic [ADDR_W-1:0] t_addr;
  logic [16:0]       t;
  logic [16:0]       u;
  logic [15:0]       r;

  // Adding 2Q before subtracting keeps t positive for every legal input pair.
  always_comb begin
    u = (t >= Q2) ? (t - Q2) : t;
    r = (u >= Q) ? 16'(u - Q) : 16'(u);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem.rd_en   <= 1'b0;
      mem.rd_addr <= '0;
      d_vld       <= 1'b0;
      d_addr      <= '0;
      t_vld       <= 1'b0;
      t_addr      <= '0;
      t           <= '0;
      mem.wr_en   <= 1'b0;
      mem.wr_addr <= '0;
      mem.dout    <= '0;
    end else begin
      done   <= 1'b0;
      d_vld  <= mem.rd_en;
      d_addr <= mem.rd_addr;
      t_vld  <= d_vld;
      t_addr <= d_addr;
      t      <= {1'b0, mem.dia} + Q2 - {1'b0, mem.dib};
      mem.wr_en <= t_vld;
      if (t_vld) begin
        mem.wr_addr <= t_addr;
        mem.dout    <= r;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            busy        <= 1'b1;
            mem.rd_en   <= 1'b1;
            mem.rd_addr <= '0;
          end
        end
        S_RUN: begin
          if (mem.rd_addr == LAST) begin
            mem.rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            mem.rd_addr <= mem.rd_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // Last write is the one with nothing left behind it in the pipe.
          if (mem.wr_en && !t_vld) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_poly_sub.sv
// tb/tb_poly_sub.sv - scoreboard bench for poly_sub with RAM models a, b and result
module tb_poly_sub;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int Q  = 12289;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  poly_sub_if #(.ADDR_W(AW)) mem_bus ();

  poly_sub #(.N(N), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .mem   (mem_bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_a [N];
  logic [15:0] mem_b [N];
  logic [15:0] mem_c [N];
  logic [15:0] ld_a  [N];
  logic [15:0] ld_b  [N];
  int          gold  [N];
  logic        do_load = 1'b0;
  logic        inplace = 1'b0;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < N; i++) begin
        mem_a[i] <= ld_a[i];
        mem_b[i] <= ld_b[i];
      end
    end
    if (mem_bus.rd_en) begin
      mem_bus.dia <= mem_a[mem_bus.rd_addr];
      mem_bus.dib <= mem_b[mem_bus.rd_addr];
    end
    if (mem_bus.wr_en) begin
      if (inplace) mem_a[mem_bus.wr_addr] <= mem_bus.dout;
      else         mem_c[mem_bus.wr_addr] <= mem_bus.dout;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  exp_t expq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int c0 = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int rd_base = 0;
  int done_base = 0;

  int ea [5] = '{12288, 0,     24577, 0,     9999};
  int eb [5] = '{0,     12288, 0,     24577, 9999};
  int ee [5] = '{12288, 1,     12288, 1,     0};

  function automatic void check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc - c0);
    end
  endfunction

  function automatic int golden(int a, int b);
    int e;
    e = (a - b) % Q;
    if (e < 0) e += Q;
    return e;
  endfunction

  // Monitor: every write must match the head of the expected queue, in order and on time.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (done) done_cnt++;
      if (mem_bus.rd_en) rd_cnt++;
      if (mem_bus.wr_en) begin
        if (expq.size() == 0) begin
          check("unexpected_write", int'(mem_bus.wr_addr), -1);
        end else begin
          e = expq.pop_front();
          check("wr_addr", int'(mem_bus.wr_addr), int'(e.addr));
          check("dout", int'(mem_bus.dout), int'(e.data));
          check("wr_cycle", cyc - c0, int'(e.addr) + 4);
        end
      end
    end
  end

  task automatic load_ram();
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic push_const(int v);
    for (int i = 0; i < N; i++) expq.push_back('{addr: AW'(i), data: 16'(v)});
  endtask

  task automatic push_golden();
    for (int i = 0; i < N; i++) begin
      gold[i] = golden(int'(ld_a[i]), int'(ld_b[i]));
      expq.push_back('{addr: AW'(i), data: 16'(gold[i])});
    end
  endtask

  task automatic issue_start();
    start   = 1'b1;
    c0      = cyc;
    rd_base = rd_cnt;
    @(negedge clk);
    start = 1'b0;
    check("rd_en_cycle1", int'(mem_bus.rd_en), 1);
    check("rd_addr_cycle1", int'(mem_bus.rd_addr), 0);
    check("busy_cycle1", int'(busy), 1);
  endtask

  task automatic wait_done(string name);
    int k;
    k = 0;
    while (!done && k < N + 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check({name, "_done_timeout"}, 0, 1);
    end else begin
      check({name, "_done_cycle"}, cyc - c0, N + 4);
      check({name, "_busy_at_done"}, int'(busy), 0);
      check({name, "_rd_count"}, rd_cnt - rd_base, N);
      check({name, "_queue_empty"}, expq.size(), 0);
    end
  endtask

  task automatic post_run(string name, int runs);
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - done_base, runs);
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_idle_rd_addr"}, int'(mem_bus.rd_addr), N - 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rd_en", int'(mem_bus.rd_en), 0);
    check("rst_rd_addr", int'(mem_bus.rd_addr), 0);
    check("rst_wr_en", int'(mem_bus.wr_en), 0);
    check("rst_wr_addr", int'(mem_bus.wr_addr), 0);
    check("rst_dout", int'(mem_bus.dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Borrow case: 5 - 7 wraps to 12287.
    for (int i = 0; i < N; i++) begin ld_a[i] = 16'd5; ld_b[i] = 16'd7; end
    load_ram();
    done_base = done_cnt;
    push_const(12287);
    issue_start();
    wait_done("basic");
    post_run("basic", 1);

    for (int i = 0; i < N; i++) begin ld_a[i] = 16'(ea[i % 5]); ld_b[i] = 16'(eb[i % 5]); end
    load_ram();
    done_base = done_cnt;
    for (int i = 0; i < N; i++) expq.push_back('{addr: AW'(i), data: 16'(ee[i % 5])});
    issue_start();
    wait_done("extremes");
    post_run("extremes", 1);

    for (int i = 0; i < N; i++) begin
      ld_a[i] = 16'($urandom_range(0, 24577));
      ld_b[i] = 16'($urandom_range(0, 24577));
    end
    load_ram();
    done_base = done_cnt;
    push_golden();
    issue_start();
    wait_done("random");
    // Back-to-back: start in cycle N+5 must be accepted.
    @(negedge clk);
    push_golden();
    issue_start();
    wait_done("b2b");
    post_run("b2b", 2);

    // Re-pulsed starts while busy and in the done cycle are ignored.
    done_base = done_cnt;
    push_golden();
    issue_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - c0 < 500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("repulse");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("repulse_rd_count", rd_cnt - rd_base, N);
    check("repulse_rd_en", int'(mem_bus.rd_en), 0);
    post_run("repulse", 1);

    for (int i = 0; i < N; i++) begin
      ld_a[i] = 16'($urandom_range(0, 24577));
      ld_b[i] = 16'($urandom_range(0, 24577));
    end
    load_ram();
    inplace = 1'b1;
    done_base = done_cnt;
    push_golden();
    issue_start();
    wait_done("inplace");
    post_run("inplace", 1);
    for (int i = 0; i < N; i++) check("inplace_ram", int'(mem_a[i]), gold[i]);
    inplace = 1'b0;

    for (int i = 0; i < N; i++) begin ld_a[i] = 16'd5; ld_b[i] = 16'd7; end
    load_ram();
    done_base = done_cnt;
    push_const(12287);
    issue_start();
    while (cyc - c0 < 300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_rd_en", int'(mem_bus.rd_en), 0);
    check("abort_rd_addr", int'(mem_bus.rd_addr), 0);
    check("abort_wr_en", int'(mem_bus.wr_en), 0);
    check("abort_wr_addr", int'(mem_bus.wr_addr), 0);
    check("abort_dout", int'(mem_bus.dout), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    expq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - done_base, 0);
    check("abort_idle_busy", int'(busy), 0);
    push_const(12287);
    issue_start();
    wait_done("after_abort");
    post_run("after_abort", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/poly_sub.md
# poly_sub

Sequencer that computes the coefficient-wise difference c = (a − b) mod q of two NewHope polynomials held in external synchronous RAMs, and streams the reduced result to a write port. It is the subtract counterpart to the coefficient-add path. The polynomial arithmetic controller uses it for the decapsulation and decryption steps that need a − b. It is launched with a one-cycle start pulse and reports completion with a one-cycle done pulse.

## Interface
- N, 1024: coefficients per polynomial (power of two, ≥ 4)
- ADDR_W, 10: address width, log2(N)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle launch pulse; ignored unless idle
- rd_en  out  1  read strobe to both source RAMs
- rd_addr  out  ADDR_W  coefficient index read from a and b
- dia  in  16  coefficient of a, valid one cycle after rd_en/rd_addr
- dib  in  16  coefficient of b, valid one cycle after rd_en/rd_addr
- wr_en  out  1  write strobe for the result RAM
- wr_addr  out  ADDR_W  result index
- dout  out  16  reduced result coefficient, valid while wr_en=1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

## Operation
- Constants: Q = 12289, 2Q = 24578. Legal inputs: dia, dib in [0, 2Q−1]. Results for out-of-range inputs are don't-care, but the sequencing must remain correct.
- Arithmetic, pipeline stage 1 (17-bit): t = dia + 2Q − dib, which lies in [1, 4Q−1]. Register t.
- Pipeline stage 2: u = t − 2Q if t ≥ 2Q, else t. Then r = u − Q if u ≥ Q, else u. Register r into dout[15:0], so dout is in [0, Q−1].
- FSM states and transitions:
  - IDLE: if start=1, go to RUN with index = 0.
  - RUN: assert rd_en with rd_addr = index and increment index. After issuing index N−1, go to DRAIN.
  - DRAIN: hold rd_en=0 while the 3-cycle pipeline empties. After the last write, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- A valid bit and address travel alongside the data. wr_addr equals the rd_addr issued 3 cycles earlier.
- In-place operation (result RAM equal to RAM a or b) is legal. A write to index k always occurs after the read of index k+2 has been issued.
- start asserted while busy=1, or in the DONE cycle, is ignored. It is not queued.
- rst at any time: return to IDLE immediately. All outputs go to 0, the pipeline valid bits clear, and no further wr_en is issued for the aborted run.

## Timing
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, dout=0, busy=0, done=0.
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Reads: read k (k = 0..N−1) is issued in cycle k+1, with rd_en=1 for exactly N consecutive cycles.
- Writes: write k occurs in cycle k+4, with wr_en=1 for exactly N consecutive cycles (cycles 4..N+3). wr_addr increments by 1 per cycle.
- Completion: done=1 in cycle N+4 only, with busy=0 in the same cycle. busy=1 in cycles 1..N+3.
- Throughput and latency: one coefficient per cycle; N+4 cycles from start to done.
- Back-to-back runs: a start sampled in cycle N+5 is accepted, giving a minimum spacing of N+5 cycles between starts.
- rd_addr holds its last value (N−1) after RUN and returns to 0 on the next accepted start. wr_addr and dout hold their last values while wr_en=0.

## Test plan
- Basic borrow case: a[k]=5, b[k]=7 for all k → every write is 12287; 1024 writes at addresses 0..1023 in cycles 4..1027; done pulse in cycle 1028.
- Range extremes:
  - a=12288, b=0 → 12288.
  - a=0, b=12288 → 1.
  - a=24577, b=0 → 12288.
  - a=0, b=24577 → 1.
  - a=b=9999 → 0.
- Random sweep: a and b uniformly random in [0, 24577] → each dout equals (a−b) mod 12289 per index, and wr_addr order is strictly 0..N−1 with no gaps.
- In-place run with the result RAM aliased to RAM a → final RAM contents match a golden model computed from the original a and b.
- Start handling:
  - start re-pulsed in cycles 1, 500, and N+4 → ignored; exactly one done pulse and N writes result.
  - start in cycle N+5 → a second run begins with rd_addr=0 in cycle N+6.
- Mid-run reset: rst asserted asynchronously mid-cycle in cycle 300 → all outputs go to 0 without waiting for a clock edge. No wr_en or done follows. A subsequent start completes a full, correct run.
